// File: rtl/enc_pkg.sv
// Shared types and helpers for the registered 8-to-3 priority encoder.
// Holds default geometry, FSM state type and the index-to-onehot helper.
package enc_pkg;

  localparam int ENC_N = 8;
  localparam int ENC_W = $clog2(ENC_N);

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } enc_state_t;

  function automatic logic [ENC_N-1:0] onehot(
    input logic [ENC_W-1:0] idx
  );
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational pending-vector picker: upward scan from base with wrap.
// Fixed build (ENC_ROUND_ROBIN_EN undefined) mirrors the vector so index N-1 wins.
module prio_pick
  import enc_pkg::*;
#(
  parameter int N = ENC_N,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec_i,
  input  logic [W-1:0] base_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  logic [N-1:0] scan;
  logic [W-1:0] pos;
  int unsigned  j;

  // Present the vector in scan order (mirrored for fixed priority)
  always_comb begin
    scan = '0;
`ifdef ENC_ROUND_ROBIN_EN
    scan = vec_i;
`else
    for (int i = 0; i < N; i++) begin
      scan[i] = vec_i[N-1-i];
    end
`endif
  end

  // First set bit at or above base, wrapping past the top
  always_comb begin
    pos   = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(base_i) + k) % N;
      if (!any_o && scan[j]) begin
        pos   = W'(j);
        any_o = 1'b1;
      end
    end
  end

  // Undo the mirror so the index refers to the original bit
  always_comb begin
`ifdef ENC_ROUND_ROBIN_EN
    idx_o = pos;
`else
    idx_o = W'(N-1) - pos;
`endif
  end

endmodule

// File: rtl/priority_encoder8x3_sync.sv
// Registered 8-to-3 priority encoder: edge capture, pending set, valid/ready out.
// Define ENC_ROUND_ROBIN_EN for rotating priority from the last accepted index.
module priority_encoder8x3_sync
  import enc_pkg::*;
#(
  parameter int N = ENC_N,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         E,
  input  logic [N-1:0] req,
  input  logic         ready,
  input  logic         ovf_clr,
  output logic [W-1:0] Y,
  output logic         V,
  output logic [N-1:0] pending_o,
  output logic         ovf
);

  logic [N-1:0] req_q;
  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] y_q, y_d;
  logic         v_q, v_d;
  logic         ovf_q, ovf_d;
  enc_state_t   state_q, state_d;

  logic [N-1:0] new_ev;
  logic [N-1:0] clr;
  logic [N-1:0] rem;
  logic         acc;
  logic [W-1:0] pk_base;
  logic [W-1:0] pk_idx;
  logic         pk_any;

`ifdef ENC_ROUND_ROBIN_EN
  logic [W-1:0] base_q, base_d;
`endif

  // Edge detect, acceptance and pending/overflow next state
  always_comb begin
    new_ev = req & ~req_q & {N{E}};
    acc    = v_q & ready;
    clr    = acc ? onehot(y_q) : '0;
    rem    = pend_q & ~clr;
    pend_d = rem | new_ev;
    ovf_d  = ovf_q;
    if (|(new_ev & pend_q & ~clr)) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Scan base: the index after the one being accepted now
`ifdef ENC_ROUND_ROBIN_EN
  always_comb begin
    base_d  = acc ? y_q + W'(1) : base_q;
    pk_base = base_d;
  end
`else
  assign pk_base = '0;
`endif

  prio_pick #(
    .N (N),
    .W (W)
  ) u_pick (
    .vec_i  (rem),
    .base_i (pk_base),
    .idx_o  (pk_idx),
    .any_o  (pk_any)
  );

  // Presentation FSM: hold Y while stalled, reload on every accept
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    v_d     = v_q;
    unique case (state_q)
      IDLE: begin
        if (|pend_q) begin
          y_d     = pk_idx;
          v_d     = 1'b1;
          state_d = VALID;
        end
      end
      VALID: begin
        if (acc) begin
          if (pk_any) begin
            y_d = pk_idx;
          end else begin
            v_d     = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        v_d     = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q   <= '0;
      pend_q  <= '0;
      y_q     <= '0;
      v_q     <= 1'b0;
      ovf_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      req_q   <= req;
      pend_q  <= pend_d;
      y_q     <= y_d;
      v_q     <= v_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
    end
  end

`ifdef ENC_ROUND_ROBIN_EN
  // Round-robin base moves only when an index is accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q <= '0;
    end else begin
      base_q <= base_d;
    end
  end
`endif

  assign Y         = y_q;
  assign V         = v_q;
  assign pending_o = pend_q;
  assign ovf       = ovf_q;

endmodule
